// File: rtl/iir_n.sv
// All-pole IIR filter: y[n] = x[n] - sum a_k*y[n-k], coefficients in Q(FRAC), one MAC per clk.
// Define IIR_N_SAT_EN to clamp out-of-range results; otherwise results wrap to N bits.
module iir_n #(
  parameter int N      = 32,
  parameter int DELAYS = 3,
  parameter int FRAC   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_d,
  input  logic                  ena,
  input  logic signed [N-1:0]   x_in,
  input  logic [DELAYS*N-1:0]   a,
  output logic signed [N-1:0]   y_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int AW = 2*N + $clog2(DELAYS+1) + 1;
  localparam int KW = (DELAYS > 1) ? $clog2(DELAYS+1) : 1;

  typedef enum logic [1:0] {IDLE, MAC, UPDATE} state_t;

  state_t                state;
  logic [KW-1:0]         k;
  logic signed [AW-1:0]  acc;
  logic signed [N-1:0]   y_hist [1:DELAYS];

  logic signed [N-1:0]   sel_a;
  logic signed [N-1:0]   sel_y;
  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0]  x_ext;
  logic signed [AW-1:0]  shifted;
  logic signed [N-1:0]   result;

  // Tap select: coefficient a_k and history y[n-k] for the current MAC cycle.
  always_comb begin
    sel_a = '0;
    sel_y = '0;
    for (int unsigned i = 1; i <= DELAYS; i++) begin
      if (k == KW'(i)) begin
        sel_a = a[(i-1)*N +: N];
        sel_y = y_hist[i];
      end
    end
  end

  assign prod    = (2*N)'(sel_a) * (2*N)'(sel_y);
  assign x_ext   = AW'(x_in);
  assign shifted = acc >>> FRAC;

`ifdef IIR_N_SAT_EN
  logic [AW-N:0] hi_bits;
  logic          out_of_range;
  assign hi_bits      = shifted[AW-1:N-1];
  assign out_of_range = !((&hi_bits) || (~|hi_bits));
  always_comb begin
    result = shifted[N-1:0];
    if (out_of_range)
      result = shifted[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end
`else
  assign result = N'(shifted);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int unsigned i = 1; i <= DELAYS; i++) y_hist[i] <= '0;
    end else if (!ena) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clk_d) begin
            acc   <= x_ext <<< FRAC;
            k     <= KW'(1);
            state <= MAC;
            busy  <= 1'b1;
          end
        end
        MAC: begin
          if (clk_d) overrun <= 1'b1;
          acc <= acc - AW'(prod);
          if (k == KW'(DELAYS)) state <= UPDATE;
          else                  k     <= k + 1'b1;
        end
        UPDATE: begin
          if (clk_d) overrun <= 1'b1;
          y_out     <= result;
          y_hist[1] <= result;
          for (int unsigned i = 2; i <= DELAYS; i++) y_hist[i] <= y_hist[i-1];
          out_valid <= 1'b1;
          k         <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
